rect_plotter: RTL and testbench

//  Parametrised pixel-stream generator for the vga_adapter plot interface.

---
 rtl/rect_plotter_if.sv | 38 +++
 rtl/rect_plotter.sv | 178 +++++++++++++++++
 tb/tb_rect_plotter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_plotter_if.sv
// rect_plotter_if
//  Bundles the plot-request and pixel-stream signals exchanged between the
//  game FSM (master) and rect_plotter (slave).
//  Request side (master -> slave): start, mode, x0, y0, w, h, colour_in
//  Pixel side   (slave -> master): x, y, colour, plot, busy, done
//  The pixel side feeds vga_adapter directly (x, y, colour, plot).
interface rect_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);

  logic                start;
  logic [1:0]          mode;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W-1:0]      w;
  logic [Y_W-1:0]      h;
  logic [COLOUR_W-1:0] colour_in;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, mode, x0, y0, w, h, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, x0, y0, w, h, colour_in,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/rect_plotter.sv
// rect_plotter
//  Pixel-stream generator for the vga_adapter plot interface. Each accepted
//  start request draws a filled rectangle, a 1-pixel outline, or clears the
//  whole screen, emitting one pixel per clock.
//  Ports:
//    clock   system clock
//    resetn  asynchronous active-low reset
//    bus     rect_plotter_if.slave: request inputs (start, mode, x0, y0, w,
//            h, colour_in) and registered pixel outputs (x, y, colour, plot,
//            busy, done)
//  Mode: 00 fill, 01 outline, 10 clear screen, 11 fill.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int MAX_W    = 16,
  parameter int MAX_H    = 16,
  parameter int COLOUR_W = 3
) (
  input logic           clock,
  input logic           resetn,
  rect_plotter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  localparam logic [1:0]     MODE_OUTLINE = 2'b01;
  localparam logic [1:0]     MODE_CLEAR   = 2'b10;
  localparam logic [X_W-1:0] ONE_X        = X_W'(1);
  localparam logic [Y_W-1:0] ONE_Y        = Y_W'(1);
  localparam logic [X_W-1:0] MAX_W_X      = X_W'(MAX_W);
  localparam logic [Y_W-1:0] MAX_H_Y      = Y_W'(MAX_H);
  localparam logic [X_W-1:0] SCREEN_W_X   = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] SCREEN_H_Y   = Y_W'(SCREEN_H);
  // Clip limits are one bit wider so that an overflowing x0+dx / y0+dy
  // compares as off-screen instead of wrapping back onto the screen.
  localparam logic [X_W:0]   LIMIT_X      = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   LIMIT_Y      = (Y_W+1)'(SCREEN_H);

  state_t              state_q;
  logic                outline_q;
  logic [X_W-1:0]      x0_q, w_q, dx_q;
  logic [Y_W-1:0]      y0_q, h_q, dy_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q, busy_q, done_q;

  logic                outline_d;
  logic [X_W-1:0]      x0_d, w_d, dx_d;
  logic [Y_W-1:0]      y0_d, h_d, dy_d;
  logic [X_W:0]        sumX_d;
  logic [Y_W:0]        sumY_d;
  logic                border_d, plot_d;
  logic                lastPix;

  // Geometry of the pixel to be presented next. In IDLE this is pixel (0,0)
  // of the incoming request (with clear forcing the full-screen rectangle);
  // in DRAW it is the successor of the current pixel in dx-fastest order.
  always_comb begin
    outline_d = outline_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    if (state_q == IDLE) begin
      outline_d = (bus.mode == MODE_OUTLINE);
      dx_d      = '0;
      dy_d      = '0;
      if (bus.mode == MODE_CLEAR) begin
        x0_d = '0;
        y0_d = '0;
        w_d  = SCREEN_W_X;
        h_d  = SCREEN_H_Y;
      end else begin
        x0_d = bus.x0;
        y0_d = bus.y0;
        w_d  = (bus.w > MAX_W_X) ? MAX_W_X : bus.w;
        h_d  = (bus.h > MAX_H_Y) ? MAX_H_Y : bus.h;
      end
    end else if (dx_q == w_q - ONE_X) begin
      dx_d = '0;
      dy_d = dy_q + ONE_Y;
    end else begin
      dx_d = dx_q + ONE_X;
    end
    sumX_d   = {1'b0, x0_d} + {1'b0, dx_d};
    sumY_d   = {1'b0, y0_d} + {1'b0, dy_d};
    border_d = (dx_d == '0) || (dx_d == w_d - ONE_X) ||
               (dy_d == '0) || (dy_d == h_d - ONE_Y);
    plot_d   = (sumX_d < LIMIT_X) && (sumY_d < LIMIT_Y) &&
               (!outline_d || border_d);
  end

  assign lastPix = (dx_q == w_q - ONE_X) && (dy_q == h_q - ONE_Y);

  // Control FSM with registered pixel outputs. Clipped and interior pixels
  // still consume their cycle so the busy length is always w*h.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      outline_q <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            outline_q <= outline_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            colour_q  <= bus.colour_in;
            if (w_d == '0 || h_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAW;
              busy_q  <= 1'b1;
              dx_q    <= dx_d;
              dy_q    <= dy_d;
              x_q     <= sumX_d[X_W-1:0];
              y_q     <= sumY_d[Y_W-1:0];
              plot_q  <= plot_d;
            end
          end
        end
        DRAW: begin
          if (lastPix) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            x_q    <= sumX_d[X_W-1:0];
            y_q    <= sumY_d[Y_W-1:0];
            plot_q <= plot_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter
//  Self-checking bench for rect_plotter: a table of shape requests, each
//  expanded by a small reference model into expected pixels on a queue that
//  is popped whenever the plotter asserts plot, plus hand-written sequences
//  for start-held-high and reset-mid-draw.
module tb_rect_plotter;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  // 100 MHz-style clock; posedges at 5, 15, 25 ...
  always #5 clock = ~clock;

  rect_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

  rect_plotter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour;
    int         expPlots;
    int         expBusy;
    int         pokeCycle;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] expQ[$];
  int          nChecks = 0;
  int          nPass   = 0;

  // Single comparison point: every check steps nChecks and, on success, nPass.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic addVec(input string name, input logic [1:0] mode, input logic [7:0] x0,
                        input logic [6:0] y0, input logic [7:0] w, input logic [6:0] h,
                        input logic [2:0] colour, input int expPlots, input int expBusy,
                        input int pokeCycle);
    vec_t v;
    v.name = name; v.mode = mode; v.x0 = x0; v.y0 = y0; v.w = w; v.h = h;
    v.colour = colour; v.expPlots = expPlots; v.expBusy = expBusy; v.pokeCycle = pokeCycle;
    vecs.push_back(v);
  endtask

  // Reference model: enumerate the request in scan order and queue every
  // pixel that should be plotted as {x, y, colour}.
  task automatic pushModel(input vec_t v);
    int ox, oy, cw, ch, px, py;
    bit on;
    if (v.mode == 2'b10) begin
      ox = 0; oy = 0; cw = 160; ch = 120;
    end else begin
      ox = int'(v.x0);
      oy = int'(v.y0);
      cw = (v.w > 8'd16) ? 16 : int'(v.w);
      ch = (v.h > 7'd16) ? 16 : int'(v.h);
    end
    for (int dy = 0; dy < ch; dy++) begin
      for (int dx = 0; dx < cw; dx++) begin
        px = ox + dx;
        py = oy + dy;
        on = (px < 160) && (py < 120);
        if (v.mode == 2'b01 && !(dx == 0 || dx == cw - 1 || dy == 0 || dy == ch - 1)) on = 1'b0;
        if (on) expQ.push_back({px[7:0], py[6:0], v.colour});
      end
    end
  endtask

  // Drive a request at the current negedge; start is sampled at the next posedge (cycle T).
  task automatic applyStimulus(input vec_t v, input bit withModel);
    bus.start     = 1'b1;
    bus.mode      = v.mode;
    bus.x0        = v.x0;
    bus.y0        = v.y0;
    bus.w         = v.w;
    bus.h         = v.h;
    bus.colour_in = v.colour;
    if (withModel) pushModel(v);
  endtask

  task automatic scrambleInputs();
    bus.mode      = 2'($urandom);
    bus.x0        = 8'($urandom);
    bus.y0        = 7'($urandom);
    bus.w         = 8'($urandom);
    bus.h         = 7'($urandom);
    bus.colour_in = 3'($urandom);
  endtask

  // Expect a plotted pixel now and compare it with the head of the queue.
  task automatic expectPixel(input string name);
    checkOutput({name, " plot"}, bus.plot, 1);
    if (expQ.size() == 0) begin
      nChecks++;
      $display("[TB] FAIL %s: got pixel %0h expected none queued", name, {bus.x, bus.y, bus.colour});
    end else begin
      checkOutput({name, " pixel"}, {bus.x, bus.y, bus.colour}, expQ.pop_front());
    end
  endtask

  // Follow one request from cycle T+1 until its done pulse (bounded), then
  // check counts, timing and that the done pulse lasts exactly one cycle.
  task automatic watchRequest(input vec_t v);
    int busyCnt  = 0;
    int plotCnt  = 0;
    int doneAt   = 0;
    int lastBusy = 0;
    for (int cyc = 1; cyc <= 20000 && doneAt == 0; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        bus.start = 1'b0;
        scrambleInputs();
      end
      if (cyc == v.pokeCycle) begin
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.w     = 8'd2;
        bus.h     = 7'd2;
      end else if (cyc == v.pokeCycle + 1) begin
        bus.start = 1'b0;
      end
      if (bus.plot) begin
        plotCnt++;
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL %s extra pixel: got %0h expected none", v.name, {bus.x, bus.y, bus.colour});
        end else begin
          checkOutput({v.name, " pixel"}, {bus.x, bus.y, bus.colour}, expQ.pop_front());
        end
      end
      if (bus.busy) begin
        busyCnt++;
        lastBusy = cyc;
      end
      if (bus.done) begin
        doneAt = cyc;
        checkOutput({v.name, " done quiet"}, {bus.plot, bus.busy}, 0);
      end
    end
    checkOutput({v.name, " plot count"}, plotCnt, v.expPlots);
    checkOutput({v.name, " busy count"}, busyCnt, v.expBusy);
    checkOutput({v.name, " last busy"}, lastBusy, v.expBusy);
    checkOutput({v.name, " done cycle"}, doneAt, v.expBusy + 1);
    checkOutput({v.name, " missing pixels"}, expQ.size(), 0);
    expQ.delete();
    @(negedge clock);
    bus.start = 1'b0;
    checkOutput({v.name, " after done"}, {bus.plot, bus.busy, bus.done}, 0);
  endtask

  initial begin
    vec_t v;
    vec_t a;
    vec_t b;

    bus.start = 1'b0;
    bus.mode = '0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.colour_in = '0;

    //     name          mode   x0      y0     w       h      col     plots  busy   poke
    addVec("fill4x4",    2'b00, 8'd10,  7'd20, 8'd4,   7'd4,  3'b101, 16,    16,    17);
    addVec("outline5x3", 2'b01, 8'd0,   7'd0,  8'd5,   7'd3,  3'b010, 12,    15,    0);
    addVec("cornerClip", 2'b00, 8'd158, 7'd118,8'd4,   7'd4,  3'b111, 4,     16,    0);
    addVec("zeroW",      2'b00, 8'd3,   7'd3,  8'd0,   7'd5,  3'b001, 0,     0,     0);
    addVec("satW",       2'b00, 8'd20,  7'd40, 8'd20,  7'd1,  3'b110, 16,    16,    0);
    addVec("midPoke",    2'b00, 8'd50,  7'd50, 8'd4,   7'd4,  3'b100, 16,    16,    5);
    addVec("mode11",     2'b11, 8'd5,   7'd5,  8'd2,   7'd3,  3'b011, 6,     6,     0);
    addVec("xOverflow",  2'b00, 8'd250, 7'd10, 8'd10,  7'd1,  3'b001, 0,     10,    0);
    addVec("outlineSatH",2'b01, 8'd100, 7'd60, 8'd3,   7'd30, 3'b101, 34,    48,    0);
    addVec("outline1x1", 2'b01, 8'd0,   7'd0,  8'd1,   7'd1,  3'b010, 1,     1,     0);
    addVec("clear",      2'b10, 8'd77,  7'd33, 8'd0,   7'd0,  3'b000, 19200, 19200, 0);

    #12;
    checkOutput("reset outputs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1);
      watchRequest(vecs[i]);
    end

    // Start held high: the second request is taken in the first IDLE cycle after done.
    a.name = "holdA"; a.mode = 2'b00; a.x0 = 8'd1; a.y0 = 7'd1; a.w = 8'd2; a.h = 7'd1; a.colour = 3'b011;
    b.name = "holdB"; b.mode = 2'b00; b.x0 = 8'd7; b.y0 = 7'd9; b.w = 8'd1; b.h = 7'd1; b.colour = 3'b110;
    applyStimulus(a, 1'b1);
    @(negedge clock);
    applyStimulus(b, 1'b1);
    expectPixel("hold A0");
    @(negedge clock);
    expectPixel("hold A1");
    @(negedge clock);
    checkOutput("hold doneA", {bus.busy, bus.done}, 2'b01);
    @(negedge clock);
    checkOutput("hold idle gap", {bus.plot, bus.busy, bus.done}, 0);
    @(negedge clock);
    bus.start = 1'b0;
    expectPixel("hold B0");
    checkOutput("hold B busy", bus.busy, 1);
    @(negedge clock);
    checkOutput("hold doneB", {bus.busy, bus.done}, 2'b01);
    @(negedge clock);
    checkOutput("hold end", {bus.plot, bus.busy, bus.done}, 0);
    checkOutput("hold queue", expQ.size(), 0);
    expQ.delete();

    // Reset asserted while pixel 7 of a 4x4 fill is on the outputs.
    v.name = "abort"; v.mode = 2'b00; v.x0 = 8'd30; v.y0 = 7'd30; v.w = 8'd4; v.h = 7'd4; v.colour = 3'b101;
    applyStimulus(v, 1'b0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (cyc == 1) bus.start = 1'b0;
    end
    checkOutput("abort pixel7", {bus.x, bus.y, bus.plot, bus.busy}, {8'd33, 7'd31, 1'b1, 1'b1});
    resetn = 1'b0;
    #1;
    checkOutput("abort outputs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      checkOutput("abort no done", {bus.plot, bus.busy, bus.done}, 0);
    end
    resetn = 1'b1;
    @(negedge clock);
    v.name = "afterReset2x2"; v.x0 = 8'd12; v.y0 = 7'd14; v.w = 8'd2; v.h = 7'd2; v.colour = 3'b001;
    v.expPlots = 4; v.expBusy = 4; v.pokeCycle = 0;
    applyStimulus(v, 1'b1);
    watchRequest(v);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
